// File: rtl/game_referee.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : game_referee                                                     |
// | Brief   : Host-command sequencer that preloads/clears a game counter,      |
// |           times each game and reports its outcome and running totals.      |
// | Rev     : 1.0                                                              |
// +----------------------------------------------------------------------------+
module game_referee #(
  parameter  int COUNT_MAX_VALUE = 15,
  localparam int W               = $clog2(COUNT_MAX_VALUE)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         cmd_valid,
  output logic         cmd_ready,
  input  logic [1:0]   cmd_op,
  input  logic [W-1:0] cmd_data,
  input  logic         abort,
  output logic [1:0]   control,
  output logic         INIT,
  output logic [W-1:0] initial_value,
  output logic         clear,
  input  logic         GAMEOVER,
  input  logic [1:0]   WHO,
  output logic         res_valid,
  input  logic         res_ready,
  output logic [1:0]   res_who,
  output logic [15:0]  res_cycles,
  output logic [7:0]   res_round,
  output logic [7:0]   win_total,
  output logic [7:0]   lose_total,
  output logic         busy
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_PRELOAD = 3'd1,
    S_CLR     = 3'd2,
    S_RUN     = 3'd3,
    S_REPORT  = 3'd4
  } state_t;

  localparam logic [1:0] c_op_start    = 2'b00;
  localparam logic [1:0] c_op_set_mode = 2'b01;
  localparam logic [1:0] c_op_load     = 2'b10;
  localparam logic [1:0] c_who_win     = 2'b10;
  localparam logic [1:0] c_who_lose    = 2'b01;

  state_t       r_state;
  state_t       w_state_next;
  logic [1:0]   r_mode;
  logic [W-1:0] r_init_value;
  logic [15:0]  r_cycles;
  logic         r_aborting;
  logic [1:0]   r_res_who;
  logic [15:0]  r_res_cycles;
  logic [7:0]   r_res_round;
  logic [7:0]   r_win_total;
  logic [7:0]   r_lose_total;

  logic         w_cmd_fire;
  logic         w_run_over;
  logic         w_run_abort;
  logic         w_enter_report;
  logic [1:0]   w_report_who;
  logic [15:0]  w_cycles_inc;

  assign w_cmd_fire     = cmd_valid && (r_state == S_IDLE);
  // GAMEOVER wins over a simultaneous abort.
  assign w_run_over     = (r_state == S_RUN) && GAMEOVER;
  assign w_run_abort    = (r_state == S_RUN) && !GAMEOVER && abort;
  assign w_cycles_inc   = (r_cycles == 16'hFFFF) ? r_cycles : r_cycles + 16'd1;
  assign w_enter_report = (w_state_next == S_REPORT) && (r_state != S_REPORT);
  assign w_report_who   = w_run_over ? WHO : 2'b00;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_cmd_fire) begin
          if (cmd_op == c_op_start)     w_state_next = S_CLR;
          else if (cmd_op == c_op_load) w_state_next = S_PRELOAD;
        end
      end
      S_PRELOAD: w_state_next = S_IDLE;
      // After an abort the clear pulse leads straight to the report.
      S_CLR:     w_state_next = r_aborting ? S_REPORT : S_RUN;
      S_RUN: begin
        if (GAMEOVER)   w_state_next = S_REPORT;
        else if (abort) w_state_next = S_CLR;
      end
      S_REPORT: if (res_ready) w_state_next = S_IDLE;
      default:  w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_mode       <= 2'b00;
      r_init_value <= '0;
      r_cycles     <= 16'd0;
      r_aborting   <= 1'b0;
      r_res_who    <= 2'b00;
      r_res_cycles <= 16'd0;
      r_res_round  <= 8'd0;
      r_win_total  <= 8'd0;
      r_lose_total <= 8'd0;
    end else begin
      if (w_cmd_fire && (cmd_op == c_op_set_mode)) r_mode <= cmd_data[1:0];
      if (w_cmd_fire && (cmd_op == c_op_load))     r_init_value <= cmd_data;
      if (w_cmd_fire && (cmd_op == c_op_start)) begin
        r_cycles   <= 16'd0;
        r_aborting <= 1'b0;
      end else if (r_state == S_RUN) begin
        r_cycles <= w_cycles_inc;
      end
      if (w_run_abort) r_aborting <= 1'b1;
      // Captured count includes the terminating RUN cycle.
      if (w_run_over || w_run_abort) begin
        r_res_who    <= w_report_who;
        r_res_cycles <= w_cycles_inc;
      end
      if (w_enter_report) begin
        r_res_round <= r_res_round + 8'd1;
        if ((r_res_who_next_win(w_run_over, w_report_who)) && (r_win_total != 8'hFF))
          r_win_total <= r_win_total + 8'd1;
        if (w_run_over && (w_report_who == c_who_lose) && (r_lose_total != 8'hFF))
          r_lose_total <= r_lose_total + 8'd1;
      end
    end
  end

  function automatic logic r_res_who_next_win(input logic over, input logic [1:0] who);
    return over && (who == c_who_win);
  endfunction

  assign cmd_ready     = (r_state == S_IDLE);
  assign busy          = (r_state != S_IDLE);
  assign control       = r_mode;
  assign INIT          = (r_state == S_PRELOAD);
  assign clear         = (r_state == S_CLR);
  assign initial_value = r_init_value;
  assign res_valid     = (r_state == S_REPORT);
  assign res_who       = r_res_who;
  assign res_cycles    = r_res_cycles;
  assign res_round     = r_res_round;
  assign win_total     = r_win_total;
  assign lose_total    = r_lose_total;

endmodule
`default_nettype wire

// File: tb/tb_game_referee.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : tb_game_referee                                                  |
// | Brief   : Scoreboard bench for game_referee command, game and report flow. |
// | Rev     : 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_game_referee;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic         cmd_valid;
  logic         cmd_ready;
  logic [1:0]   cmd_op;
  logic [W-1:0] cmd_data;
  logic         abort;
  logic [1:0]   control;
  logic         INIT;
  logic [W-1:0] initial_value;
  logic         clear;
  logic         GAMEOVER;
  logic [1:0]   WHO;
  logic         res_valid;
  logic         res_ready;
  logic [1:0]   res_who;
  logic [15:0]  res_cycles;
  logic [7:0]   res_round;
  logic [7:0]   win_total;
  logic [7:0]   lose_total;
  logic         busy;

  typedef struct {
    logic [1:0]  who;
    logic [15:0] cyc;
    logic        chk_cyc;
    logic [7:0]  round;
    logic [7:0]  win;
    logic [7:0]  lose;
  } exp_t;

  exp_t sb[$];
  int   n_vec   = 0;
  int   n_err   = 0;
  int   n_clear = 0;
  int   n_init  = 0;
  int   n_both  = 0;
  logic [7:0] m_round = 8'd0;
  logic [7:0] m_win   = 8'd0;
  logic [7:0] m_lose  = 8'd0;

  game_referee #(.COUNT_MAX_VALUE(15)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_data(cmd_data),
    .abort(abort), .control(control), .INIT(INIT), .initial_value(initial_value),
    .clear(clear), .GAMEOVER(GAMEOVER), .WHO(WHO),
    .res_valid(res_valid), .res_ready(res_ready), .res_who(res_who),
    .res_cycles(res_cycles), .res_round(res_round),
    .win_total(win_total), .lose_total(lose_total), .busy(busy)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (clear)          n_clear++;
    if (INIT)           n_init++;
    if (clear && INIT)  n_both++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_cmd(input logic [1:0] op, input logic [W-1:0] data);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_data  = data;
    tick();
    cmd_valid = 1'b0;
    cmd_op    = 2'b11;
  endtask

  // Called one tick after a START handshake (block in CLR); ends the game on RUN cycle n.
  task automatic play(input int n, input logic go, input logic [1:0] who, input logic ab);
    exp_t e;
    tick();
    for (int i = 1; i < n; i++) tick();
    GAMEOVER = go;
    WHO      = who;
    abort    = ab;
    e.who     = go ? who : 2'b00;
    e.cyc     = 16'(n);
    e.chk_cyc = go;
    m_round   = m_round + 8'd1;
    if (e.who == 2'b10 && m_win  != 8'hFF) m_win  = m_win + 8'd1;
    if (e.who == 2'b01 && m_lose != 8'hFF) m_lose = m_lose + 8'd1;
    e.round = m_round;
    e.win   = m_win;
    e.lose  = m_lose;
    sb.push_back(e);
    tick();
    GAMEOVER = 1'b0;
    WHO      = 2'b00;
    abort    = 1'b0;
  endtask

  task automatic wait_result();
    exp_t e;
    int   k;
    k = 0;
    while (!res_valid && k < 20) begin
      tick();
      k++;
    end
    check("res_valid_timeout", res_valid, 1'b1);
    if (sb.size() == 0) begin
      check("sb_underflow", 32'(sb.size()), 32'd1);
    end else begin
      e = sb.pop_front();
      check("res_who", res_who, e.who);
      if (e.chk_cyc) check("res_cycles", res_cycles, e.cyc);
      check("res_round", res_round, e.round);
      check("win_total", win_total, e.win);
      check("lose_total", lose_total, e.lose);
    end
  endtask

  task automatic accept_result();
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    check("res_valid_drop", res_valid, 1'b0);
    check("ready_after_rep", cmd_ready, 1'b1);
  endtask

  initial begin
    int c0;
    logic [1:0]  h_who;
    logic [15:0] h_cyc;
    logic [7:0]  h_rnd;
    rst = 1'b0; cmd_valid = 1'b0; cmd_op = 2'b11; cmd_data = '0;
    abort = 1'b0; GAMEOVER = 1'b0; WHO = 2'b00; res_ready = 1'b0;

    #3;
    check("rst_busy", busy, 1'b0);
    check("rst_res_valid", res_valid, 1'b0);
    check("rst_control", control, 2'b00);
    check("rst_init_val", initial_value, 4'd0);
    check("rst_strobes", {INIT, clear}, 2'b00);
    check("rst_counts", {res_round, win_total, lose_total}, 24'd0);
    check("rst_res", {res_who, res_cycles}, 18'd0);
    repeat (2) tick();
    check("rst_held_ready", cmd_ready, 1'b1);
    rst = 1'b1;

    // Mode then START, with a stray LOAD held during the game.
    send_cmd(2'b01, 4'd2);
    check("mode_control", control, 2'b10);
    check("mode_idle", busy, 1'b0);
    c0 = n_clear;
    send_cmd(2'b00, 4'd0);
    check("start_clear", clear, 1'b1);
    check("start_busy", busy, 1'b1);
    check("start_ready", cmd_ready, 1'b0);
    cmd_valid = 1'b1; cmd_op = 2'b10; cmd_data = 4'd5;
    play(20, 1'b1, 2'b10, 1'b0);
    cmd_valid = 1'b0; cmd_op = 2'b11;
    wait_result();
    check("game1_clears", 32'(n_clear - c0), 32'd1);
    check("busy_cmd_ignored", initial_value, 4'd0);
    h_who = res_who; h_cyc = res_cycles; h_rnd = res_round;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("hold_valid", res_valid, 1'b1);
      check("hold_fields", {res_who, res_cycles, res_round}, {h_who, h_cyc, h_rnd});
    end
    accept_result();

    // LOAD preload strobe.
    c0 = n_init;
    send_cmd(2'b10, 4'd9);
    check("load_init", INIT, 1'b1);
    check("load_value", initial_value, 4'd9);
    check("load_no_clear", clear, 1'b0);
    tick();
    check("load_init_end", INIT, 1'b0);
    check("load_ready", cmd_ready, 1'b1);
    check("load_value_hold", initial_value, 4'd9);
    check("load_pulses", 32'(n_init - c0), 32'd1);

    // NOP and GAMEOVER in IDLE are ignored.
    GAMEOVER = 1'b1; WHO = 2'b10;
    send_cmd(2'b11, 4'd3);
    tick();
    GAMEOVER = 1'b0; WHO = 2'b00;
    check("idle_ignore", {busy, control, win_total}, {1'b0, 2'b10, 8'd1});

    // GAMEOVER beats simultaneous abort.
    c0 = n_clear;
    send_cmd(2'b00, 4'd0);
    play(7, 1'b1, 2'b01, 1'b1);
    check("both_no_clear", clear, 1'b0);
    wait_result();
    accept_result();
    check("both_clears", 32'(n_clear - c0), 32'd1);

    // Abort alone: clear pulse, then an empty report.
    c0 = n_clear;
    send_cmd(2'b00, 4'd0);
    play(5, 1'b0, 2'b10, 1'b1);
    check("abort_clear", clear, 1'b1);
    wait_result();
    accept_result();
    check("abort_clears", 32'(n_clear - c0), 32'd2);

    // Illegal WHO counts as neither.
    send_cmd(2'b00, 4'd0);
    play(3, 1'b1, 2'b11, 1'b0);
    wait_result();
    accept_result();

    // Reset while reporting.
    send_cmd(2'b00, 4'd0);
    play(4, 1'b1, 2'b10, 1'b0);
    wait_result();
    #2 rst = 1'b0;
    #1;
    check("rpt_rst_valid", res_valid, 1'b0);
    check("rpt_rst_counts", {res_round, win_total, lose_total}, 24'd0);
    check("rpt_rst_busy", busy, 1'b0);
    m_round = 8'd0; m_win = 8'd0; m_lose = 8'd0;
    tick();
    rst = 1'b1;
    tick();
    check("rpt_rst_idle", cmd_ready, 1'b1);

    // Reset mid-RUN emits no strobe.
    c0 = n_clear;
    send_cmd(2'b00, 4'd0);
    repeat (3) tick();
    rst = 1'b0;
    #1;
    check("run_rst_strobes", {INIT, clear, busy}, 3'b000);
    tick();
    rst = 1'b1;
    check("run_rst_clears", 32'(n_clear - c0), 32'd1);

    send_cmd(2'b00, 4'd0);
    play(2, 1'b1, 2'b01, 1'b0);
    wait_result();
    accept_result();

    check("init_clear_overlap", 32'(n_both), 32'd0);
    check("sb_drained", 32'(sb.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule
`default_nettype wire
